// File: rtl/imem_boot_pkg.sv
// Shared state encoding and counter-width helper for the instruction memory boot loader.
package imem_boot_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_HOLD = 3'd2,
        ST_RUN  = 3'd3,
        ST_ERR  = 3'd4
    } boot_state_t;

    // Bits needed to hold the values 0..max_count inclusive.
    function automatic int unsigned cnt_width(input int unsigned max_count);
        return (max_count < 1) ? 1 : int'($clog2(max_count + 1));
    endfunction

endpackage

// File: rtl/boot_reset_stretch.sv
// Down-counter that keeps the core-reset stretch active for RESET_CYCLES cycles after a load pulse.
module boot_reset_stretch
    import imem_boot_pkg::*;
#(
    parameter int unsigned RESET_CYCLES = 2
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_load,
    output logic o_active
);

    localparam int unsigned CW = cnt_width(RESET_CYCLES);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= CW'(RESET_CYCLES);
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - CW'(1);
        end
    end

    assign o_active = (r_cnt != '0);

endmodule

// File: rtl/imem_boot_loader.sv
// Streams instruction words into instruction memory from a latched base address and
// sequences the core reset around the load.
module imem_boot_loader
    import imem_boot_pkg::*;
#(
    parameter int unsigned DATA_W       = 16,
    parameter int unsigned ADDR_W       = 32,
    parameter int unsigned MAX_WORDS    = 1024,
    parameter int unsigned RESET_CYCLES = 2
) (
    input  logic                               i_clk,
    input  logic                               i_rst,
    input  logic                               i_start,
    input  logic [ADDR_W-1:0]                  i_base_addr,
    input  logic                               i_s_valid,
    input  logic [DATA_W-1:0]                  i_s_data,
    input  logic                               i_s_last,
    output logic                               o_s_ready,
    output logic                               o_mem_we,
    output logic [ADDR_W-1:0]                  o_mem_addr,
    output logic [DATA_W-1:0]                  o_mem_wdata,
    output logic                               o_cpu_reset,
    output logic                               o_busy,
    output logic                               o_done,
    output logic                               o_error,
    output logic [cnt_width(MAX_WORDS)-1:0]    o_word_count
);

    localparam int unsigned CNT_W = cnt_width(MAX_WORDS);

    boot_state_t       r_state;
    logic [ADDR_W-1:0] r_base;
    logic [CNT_W-1:0]  r_word_count;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic              r_cpu_reset;
    logic              r_busy;
    logic              r_done;
    logic              r_error;

    logic              w_hs;
    logic              w_stretch_load;
    logic              w_stretch_active;
    logic [CNT_W-1:0]  w_count_nxt;

    assign w_hs           = (r_state == ST_LOAD) && i_s_valid;
    assign w_stretch_load = w_hs && i_s_last;
    assign w_count_nxt    = r_word_count + CNT_W'(1);

    boot_reset_stretch #(
        .RESET_CYCLES (RESET_CYCLES)
    ) u_stretch (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_load   (w_stretch_load),
        .o_active (w_stretch_active)
    );

    // Control FSM with registered write port and status flags.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state      <= ST_IDLE;
            r_base       <= '0;
            r_word_count <= '0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_cpu_reset  <= 1'b1;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_error      <= 1'b0;
        end else begin
            r_mem_we <= 1'b0;
            case (r_state)
                ST_IDLE, ST_RUN, ST_ERR: begin
                    if (i_start) begin
                        r_state      <= ST_LOAD;
                        r_base       <= i_base_addr;
                        r_word_count <= '0;
                        r_cpu_reset  <= 1'b1;
                        r_busy       <= 1'b1;
                        r_done       <= 1'b0;
                        r_error      <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    if (w_hs) begin
                        r_mem_we     <= 1'b1;
                        r_mem_addr   <= r_base + ADDR_W'(r_word_count);
                        r_mem_wdata  <= i_s_data;
                        r_word_count <= w_count_nxt;
                        if (i_s_last) begin
                            r_state <= ST_HOLD;
                        end else if (w_count_nxt == CNT_W'(MAX_WORDS)) begin
                            r_state <= ST_ERR;
                            r_busy  <= 1'b0;
                            r_error <= 1'b1;
                        end
                    end
                end
                ST_HOLD: begin
                    // The stretch was loaded on the final-write edge, so it is active on entry.
                    if (!w_stretch_active) begin
                        r_state     <= ST_RUN;
                        r_cpu_reset <= 1'b0;
                        r_busy      <= 1'b0;
                        r_done      <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_s_ready    = (r_state == ST_LOAD);
    assign o_mem_we     = r_mem_we;
    assign o_mem_addr   = r_mem_addr;
    assign o_mem_wdata  = r_mem_wdata;
    assign o_cpu_reset  = r_cpu_reset;
    assign o_busy       = r_busy;
    assign o_done       = r_done;
    assign o_error      = r_error;
    assign o_word_count = r_word_count;

endmodule
